// File: rtl/pkt_arbiter_2to1_if.sv
// AXI-Stream bundle shared by the arbiter's two inputs and its output.
//   tdata/tkeep/tuser/tvalid/tlast : driven by the master side
//   tready                         : driven by the slave side
// modport master: the side that sources beats (arbiter output).
// modport slave : the side that sinks beats (arbiter inputs).
interface pkt_arbiter_2to1_if #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128
) ();

  localparam int unsigned KeepWidth = C_S_AXIS_DATA_WIDTH / 8;

  logic [C_S_AXIS_DATA_WIDTH-1:0]  tdata;
  logic [KeepWidth-1:0]            tkeep;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser;
  logic                            tvalid;
  logic                            tlast;
  logic                            tready;

  modport master (
    output tdata,
    output tkeep,
    output tuser,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tuser,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/pkt_arbiter_2to1.sv
// Two-input, packet-granular round-robin AXI-Stream arbiter.
// Shares one downstream AXIS port between two sources without ever interleaving beats of
// different packets, and counts completed packets per input.
//
// Ports:
//   clk        : single clock
//   reset      : asynchronous, active-high reset
//   s0_axis    : input 0 (slave modport), tready driven here
//   s1_axis    : input 1 (slave modport), tready driven here
//   m_axis     : registered output (master modport)
//   pkt_cnt_0  : packets fully forwarded from input 0 (wraps)
//   pkt_cnt_1  : packets fully forwarded from input 1 (wraps)
module pkt_arbiter_2to1 #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned CNT_WIDTH            = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  pkt_arbiter_2to1_if.slave    s0_axis,
  pkt_arbiter_2to1_if.slave    s1_axis,
  pkt_arbiter_2to1_if.master   m_axis,
  output logic [CNT_WIDTH-1:0] pkt_cnt_0,
  output logic [CNT_WIDTH-1:0] pkt_cnt_1
);

  localparam int unsigned KeepWidth = C_S_AXIS_DATA_WIDTH / 8;

  localparam logic StIdle = 1'b0;
  localparam logic StPass = 1'b1;

  logic state_q, state_d;
  logic grant_q, grant_d;
  logic last_grant_q, last_grant_d;

  logic [C_S_AXIS_DATA_WIDTH-1:0]  m_data_q, m_data_d;
  logic [KeepWidth-1:0]            m_keep_q, m_keep_d;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] m_user_q, m_user_d;
  logic                            m_valid_q, m_valid_d;
  logic                            m_last_q, m_last_d;

  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

  logic                            slot_free;
  logic                            g_valid;
  logic                            g_last;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  g_data;
  logic [KeepWidth-1:0]            g_keep;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] g_user;
  logic                            accept;

  // Output register can take a new beat when empty or being drained this cycle.
  assign slot_free = !m_valid_q || m_axis.tready;

  // Granted-source mux.
  assign g_valid = grant_q ? s1_axis.tvalid : s0_axis.tvalid;
  assign g_last  = grant_q ? s1_axis.tlast  : s0_axis.tlast;
  assign g_data  = grant_q ? s1_axis.tdata  : s0_axis.tdata;
  assign g_keep  = grant_q ? s1_axis.tkeep  : s0_axis.tkeep;
  assign g_user  = grant_q ? s1_axis.tuser  : s0_axis.tuser;

  // tready never looks at the same input's tvalid, only at state/grant/downstream.
  assign s0_axis.tready = (state_q == StPass) && !grant_q && slot_free;
  assign s1_axis.tready = (state_q == StPass) &&  grant_q && slot_free;

  assign accept = (state_q == StPass) && g_valid && slot_free;

  // Arbitration and packet tracking.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    unique case (state_q)
      StIdle: begin
        if (s0_axis.tvalid && s1_axis.tvalid) begin
          grant_d = ~last_grant_q;
          state_d = StPass;
        end else if (s0_axis.tvalid) begin
          grant_d = 1'b0;
          state_d = StPass;
        end else if (s1_axis.tvalid) begin
          grant_d = 1'b1;
          state_d = StPass;
        end
      end
      StPass: begin
        if (accept && g_last) begin
          last_grant_d = grant_q;
          state_d      = StIdle;
          if (grant_q) cnt1_d = cnt1_q + CNT_WIDTH'(1);
          else         cnt0_d = cnt0_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output register: load on accept, empty when drained without a replacement, else hold.
  always_comb begin
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_user_d  = m_user_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;
    if (accept) begin
      m_data_d  = g_data;
      m_keep_d  = g_keep;
      m_user_d  = g_user;
      m_last_d  = g_last;
      m_valid_d = 1'b1;
    end else if (slot_free) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      // Input 0 wins the first contention after reset.
      last_grant_q <= 1'b1;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_user_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_user_q     <= m_user_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign m_axis.tdata  = m_data_q;
  assign m_axis.tkeep  = m_keep_q;
  assign m_axis.tuser  = m_user_q;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tlast  = m_last_q;

  assign pkt_cnt_0 = cnt0_q;
  assign pkt_cnt_1 = cnt1_q;

endmodule

// File: tb/tb_pkt_arbiter_2to1.sv
// Directed self-checking bench for pkt_arbiter_2to1.
module tb_pkt_arbiter_2to1;

  localparam int unsigned DW = 64;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned UW = 16;
  localparam int unsigned CW = 4;

  logic clk;
  logic reset;
  logic [CW-1:0] pkt_cnt_0;
  logic [CW-1:0] pkt_cnt_1;

  pkt_arbiter_2to1_if #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW)) s0_if ();
  pkt_arbiter_2to1_if #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW)) s1_if ();
  pkt_arbiter_2to1_if #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW)) m_if ();

  pkt_arbiter_2to1 #(
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .CNT_WIDTH           (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s0_axis  (s0_if),
    .s1_axis  (s1_if),
    .m_axis   (m_if),
    .pkt_cnt_0(pkt_cnt_0),
    .pkt_cnt_1(pkt_cnt_1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DW-1:0] cap_data[$];
  logic [KW-1:0] cap_keep[$];
  logic [UW-1:0] cap_user[$];
  logic          cap_last[$];
  int            cap_cyc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output handshakes seen at the negedge complete at the following posedge.
  always @(negedge clk) begin
    if (!reset && m_if.tvalid && m_if.tready) begin
      cap_data.push_back(m_if.tdata);
      cap_keep.push_back(m_if.tkeep);
      cap_user.push_back(m_if.tuser);
      cap_last.push_back(m_if.tlast);
      cap_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  function automatic logic [DW-1:0] mk_data(input int src, input int pkt, input int beat);
    return {8'(src), 8'(pkt), 8'(beat), 40'hC3_5A_0F_96_11};
  endfunction

  function automatic logic [KW-1:0] mk_keep(input int beat);
    logic [KW-1:0] k;
    k = '1;
    return k >> beat;
  endfunction

  function automatic logic [UW-1:0] mk_user(input int pkt, input int beat);
    return 16'(pkt * 16 + beat) ^ 16'hBEEF;
  endfunction

  function automatic logic rdy(input int src);
    return (src == 1) ? s1_if.tready : s0_if.tready;
  endfunction

  task automatic set_src(input int src, input logic v, input logic [DW-1:0] d,
                         input logic [KW-1:0] k, input logic [UW-1:0] u, input logic l);
    if (src == 1) begin
      s1_if.tvalid = v; s1_if.tdata = d; s1_if.tkeep = k; s1_if.tuser = u; s1_if.tlast = l;
    end else begin
      s0_if.tvalid = v; s0_if.tdata = d; s0_if.tkeep = k; s0_if.tuser = u; s0_if.tlast = l;
    end
  endtask

  // Present one beat and return just after the posedge where it was accepted.
  task automatic drive_beat(input int src, input logic [DW-1:0] d, input logic [KW-1:0] k,
                            input logic [UW-1:0] u, input logic l);
    bit ok;
    ok = 0;
    set_src(src, 1'b1, d, k, u, l);
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (rdy(src)) ok = 1;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL handshake_timeout src%0d: tready got 0 for 100 cycles, required 1", src);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_pkts(input int src, input int npkts, input int nbeats, input int base);
    for (int p = 0; p < npkts; p++)
      for (int b = 0; b < nbeats; b++)
        drive_beat(src, mk_data(src, base + p, b), mk_keep(b), mk_user(base + p, b),
                   b == nbeats - 1);
    set_src(src, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic clear_caps();
    cap_data.delete(); cap_keep.delete(); cap_user.delete(); cap_last.delete(); cap_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_src(0, 1'b0, '0, '0, '0, 1'b0);
    set_src(1, 1'b0, '0, '0, '0, 1'b0);
    m_if.tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_caps();
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_src(0, 1'b1, '1, '1, '1, 1'b1);
    set_src(1, 1'b1, '1, '1, '1, 1'b1);
    m_if.tready = 1'b1;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (m_if.tvalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_tvalid: got %b, required 0", m_if.tvalid);
    end
    n_checks++;
    if (m_if.tdata !== '0) begin
      n_fail++; $display("FAIL reset_tdata: got %h, required 0", m_if.tdata);
    end
    n_checks++;
    if (m_if.tkeep !== '0 || m_if.tuser !== '0 || m_if.tlast !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_side: got keep=%h user=%h last=%b, required 0/0/0",
               m_if.tkeep, m_if.tuser, m_if.tlast);
    end
    n_checks++;
    if (pkt_cnt_0 !== '0 || pkt_cnt_1 !== '0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d, required 0/0", pkt_cnt_0, pkt_cnt_1);
    end
    n_checks++;
    if (s0_if.tready !== 1'b0 || s1_if.tready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tready: got %b/%b, required 0/0", s0_if.tready, s1_if.tready);
    end
    do_reset();
  endtask

  task automatic test_single();
    int t0;
    do_reset();
    t0 = cyc;
    drive_pkts(0, 1, 3, 0);
    drain();
    n_checks++;
    if (cap_data.size() !== 3) begin
      n_fail++; $display("FAIL single_count: got %0d beats, required 3", cap_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (cap_data[i] !== mk_data(0, 0, i) || cap_keep[i] !== mk_keep(i) ||
            cap_user[i] !== mk_user(0, i) || cap_last[i] !== (i == 2)) begin
          n_fail++;
          $display("FAIL single_beat%0d: got %h/%h/%h/%b, required %h/%h/%h/%b", i, cap_data[i],
                   cap_keep[i], cap_user[i], cap_last[i], mk_data(0, 0, i), mk_keep(i),
                   mk_user(0, i), i == 2);
        end
        n_checks++;
        if (cap_cyc[i] !== t0 + 2 + i) begin
          n_fail++;
          $display("FAIL single_timing%0d: got cycle %0d, required %0d", i, cap_cyc[i], t0 + 2 + i);
        end
      end
    end
    n_checks++;
    if (pkt_cnt_0 !== 4'd1 || pkt_cnt_1 !== 4'd0) begin
      n_fail++; $display("FAIL single_cnt: got %0d/%0d, required 1/0", pkt_cnt_0, pkt_cnt_1);
    end
  endtask

  task automatic test_contention();
    do_reset();
    fork
      drive_pkts(0, 1, 2, 0);
      drive_pkts(1, 1, 2, 0);
    join
    drain();
    n_checks++;
    if (cap_data.size() !== 4) begin
      n_fail++; $display("FAIL contention_count: got %0d beats, required 4", cap_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (cap_data[i] !== mk_data(i / 2, 0, i % 2) || cap_last[i] !== (i % 2 == 1)) begin
          n_fail++;
          $display("FAIL contention_beat%0d: got %h/%b, required %h/%b", i, cap_data[i],
                   cap_last[i], mk_data(i / 2, 0, i % 2), i % 2 == 1);
        end
      end
      n_checks++;
      if (cap_cyc[2] - cap_cyc[1] !== 2) begin
        n_fail++;
        $display("FAIL contention_bubble: got gap %0d, required 2", cap_cyc[2] - cap_cyc[1]);
      end
    end
    n_checks++;
    if (pkt_cnt_0 !== 4'd1 || pkt_cnt_1 !== 4'd1) begin
      n_fail++; $display("FAIL contention_cnt: got %0d/%0d, required 1/1", pkt_cnt_0, pkt_cnt_1);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    fork
      drive_pkts(0, 10, 1, 0);
      drive_pkts(1, 10, 1, 0);
    join
    drain();
    n_checks++;
    if (cap_data.size() !== 20) begin
      n_fail++; $display("FAIL fair_count: got %0d beats, required 20", cap_data.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        n_checks++;
        if (cap_data[i] !== mk_data(i % 2, i / 2, 0)) begin
          n_fail++;
          $display("FAIL fair_order%0d: got %h, required %h", i, cap_data[i],
                   mk_data(i % 2, i / 2, 0));
        end
      end
    end
    n_checks++;
    if (pkt_cnt_0 !== 4'd10 || pkt_cnt_1 !== 4'd10) begin
      n_fail++; $display("FAIL fair_cnt: got %0d/%0d, required 10/10", pkt_cnt_0, pkt_cnt_1);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    fork
      drive_pkts(0, 1, 4, 3);
      begin
        bit found;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
          @(negedge clk);
          if (m_if.tvalid) found = 1;
        end
        // Stall while the second beat sits in the output register.
        @(posedge clk);
        #1 m_if.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          n_checks++;
          if (m_if.tvalid !== 1'b1 || m_if.tdata !== mk_data(0, 3, 1) || m_if.tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold%0d: got v=%b d=%h l=%b, required 1/%h/0", i, m_if.tvalid,
                     m_if.tdata, m_if.tlast, mk_data(0, 3, 1));
          end
          n_checks++;
          if (s0_if.tready !== 1'b0) begin
            n_fail++; $display("FAIL bp_tready%0d: got %b, required 0", i, s0_if.tready);
          end
        end
        @(posedge clk);
        #1 m_if.tready = 1'b1;
      end
    join
    drain();
    n_checks++;
    if (cap_data.size() !== 4) begin
      n_fail++; $display("FAIL bp_count: got %0d beats, required 4", cap_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (cap_data[i] !== mk_data(0, 3, i) || cap_keep[i] !== mk_keep(i) ||
            cap_user[i] !== mk_user(3, i) || cap_last[i] !== (i == 3)) begin
          n_fail++;
          $display("FAIL bp_beat%0d: got %h/%b, required %h/%b", i, cap_data[i], cap_last[i],
                   mk_data(0, 3, i), i == 3);
        end
      end
    end
  endtask

  task automatic test_input_stall();
    do_reset();
    fork
      begin
        drive_beat(0, mk_data(0, 5, 0), mk_keep(0), mk_user(5, 0), 1'b0);
        drive_beat(0, mk_data(0, 5, 1), mk_keep(1), mk_user(5, 1), 1'b0);
        set_src(0, 1'b0, '0, '0, '0, 1'b0);
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          n_checks++;
          if (s1_if.tready !== 1'b0) begin
            n_fail++; $display("FAIL stall_other_tready%0d: got %b, required 0", g, s1_if.tready);
          end
          if (g >= 1) begin
            n_checks++;
            if (m_if.tvalid !== 1'b0) begin
              n_fail++; $display("FAIL stall_drain%0d: got tvalid %b, required 0", g, m_if.tvalid);
            end
          end
          @(posedge clk);
          #1;
        end
        drive_beat(0, mk_data(0, 5, 2), mk_keep(2), mk_user(5, 2), 1'b0);
        drive_beat(0, mk_data(0, 5, 3), mk_keep(3), mk_user(5, 3), 1'b1);
        set_src(0, 1'b0, '0, '0, '0, 1'b0);
      end
      drive_pkts(1, 1, 1, 7);
    join
    drain();
    n_checks++;
    if (cap_data.size() !== 5) begin
      n_fail++; $display("FAIL stall_count: got %0d beats, required 5", cap_data.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        logic [DW-1:0] exp_d;
        exp_d = (i < 4) ? mk_data(0, 5, i) : mk_data(1, 7, 0);
        n_checks++;
        if (cap_data[i] !== exp_d || cap_last[i] !== (i >= 3)) begin
          n_fail++;
          $display("FAIL stall_beat%0d: got %h/%b, required %h/%b", i, cap_data[i], cap_last[i],
                   exp_d, i >= 3);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_beat(0, mk_data(0, 2, 0), mk_keep(0), mk_user(2, 0), 1'b0);
    drive_beat(0, mk_data(0, 2, 1), mk_keep(1), mk_user(2, 1), 1'b0);
    n_checks++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== mk_data(0, 2, 1)) begin
      n_fail++;
      $display("FAIL rmid_pre: got v=%b d=%h, required 1/%h", m_if.tvalid, m_if.tdata,
               mk_data(0, 2, 1));
    end
    set_src(0, 1'b1, mk_data(0, 2, 2), mk_keep(2), mk_user(2, 2), 1'b0);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (m_if.tvalid !== 1'b0 || m_if.tdata !== '0 || m_if.tkeep !== '0 ||
        m_if.tuser !== '0 || m_if.tlast !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_out: got v=%b d=%h k=%h u=%h l=%b, required all 0", m_if.tvalid,
               m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast);
    end
    n_checks++;
    if (s0_if.tready !== 1'b0 || pkt_cnt_0 !== '0) begin
      n_fail++;
      $display("FAIL rmid_ready_cnt: got tready=%b cnt=%0d, required 0/0", s0_if.tready, pkt_cnt_0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s0_if.tready !== 1'b0) begin
      n_fail++; $display("FAIL rmid_idle: got tready %b after reset, required 0", s0_if.tready);
    end
    set_src(0, 1'b0, '0, '0, '0, 1'b0);
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    drive_pkts(1, 17, 1, 0);
    drain();
    n_checks++;
    if (cap_data.size() !== 17) begin
      n_fail++; $display("FAIL wrap_count: got %0d beats, required 17", cap_data.size());
    end
    n_checks++;
    if (pkt_cnt_1 !== 4'd1 || pkt_cnt_0 !== 4'd0) begin
      n_fail++; $display("FAIL wrap_cnt: got %0d/%0d, required 0/1", pkt_cnt_0, pkt_cnt_1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_input_stall();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_arbiter_2to1.md
# pkt_arbiter_2to1

Two-input, packet-granular round-robin AXI-Stream arbiter for the RMT pipeline. It shares the single packet-filter ingress between two sources, for example a MAC port and the host/DMA injection path. It never interleaves beats of different packets, and it counts completed packets per input. It sits directly upstream of the packet filter and drives its slave AXIS port.

## Interface
- C_S_AXIS_DATA_WIDTH, 256, tdata width; tkeep width is C_S_AXIS_DATA_WIDTH/8.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width.
- CNT_WIDTH, 32, width of each per-input packet counter.
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- s0_axis_tdata / s0_axis_tkeep / s0_axis_tuser  in  DATA / DATA/8 / TUSER  input 0 beat.
- s0_axis_tvalid, s0_axis_tlast  in  1  input 0 valid and end-of-packet.
- s0_axis_tready  out  1  input 0 ready.
- s1_axis_*  same set as s0  input 1.
- m_axis_tdata / m_axis_tkeep / m_axis_tuser  out  DATA / DATA/8 / TUSER  registered output beat.
- m_axis_tvalid, m_axis_tlast  out  1  registered output valid and end-of-packet.
- m_axis_tready  in  1  downstream ready.
- pkt_cnt_0, pkt_cnt_1  out  CNT_WIDTH  packets fully forwarded from input 0 and input 1.

## Operation
- FSM states: IDLE and PASS. Registers: grant (1 bit), last_grant (1 bit).
- IDLE:
  - Neither s*_tvalid set: stay in IDLE.
  - Exactly one input valid: grant is set to that input, next state PASS.
  - Both valid: grant = ~last_grant, next state PASS.
  - Both tready are 0 in IDLE.
- PASS:
  - Output slot free when `!m_axis_tvalid || m_axis_tready`.
  - sN_axis_tready = (grant==N) && slot free. The non-granted tready is 0.
  - Accept = granted tvalid && granted tready. On accept, tdata/tkeep/tuser/tlast are copied unchanged into the m_axis registers and m_axis_tvalid is set to 1.
  - Slot free but no accept: m_axis_tvalid is cleared to 0.
  - Accepted beat with tlast=1: last_grant is set to grant, pkt_cnt_<grant> increments (wraps modulo 2^CNT_WIDTH), next state IDLE.
- Output hold: when m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* outputs hold their values.
- The block drops nothing and has no internal FIFO. Back-pressure propagates directly to the granted source.
- Beat content is passed through unchanged, including tkeep. Single-beat packets (tlast on the first beat) are legal.

## Timing
- Reset values: all m_axis_* = 0, pkt_cnt_0 = pkt_cnt_1 = 0, state = IDLE, grant = 0, last_grant = 1. Input 0 therefore wins the first contention.
- Arbitration bubble: 1 cycle per packet. The first-beat handshake happens no earlier than the cycle after tvalid is seen in IDLE.
- Latency: 1 cycle from input accept to m_axis_tvalid. Full throughput of 1 beat/cycle within a packet while m_axis_tready=1.
- tready depends combinationally on m_axis_tready, state and grant. It never depends on the same input's tvalid.
- Counter update: the counter increments in the cycle after the tlast accept, i.e. it is visible together with the m_axis beat carrying tlast.
- Simultaneous events:
  - A new tvalid arriving during PASS does not change grant.
  - An input deasserting tvalid mid-packet leaves the FSM in PASS. m_axis_tvalid drops once the output slot drains.
- Reset asserted mid-packet: all registers return to reset values immediately. The partial packet is truncated and no tlast is emitted; recovery is the responsibility of the upstream sources.

## Test plan
- Single source: input 0 sends a 3-beat packet with input 1 idle and m_axis_tready=1 -> 3 output beats on consecutive cycles starting 2 cycles after the first s0 tvalid, tlast on beat 3, pkt_cnt_0=1.
- Contention after reset: both inputs valid simultaneously with 2-beat packets -> input 0 packet is forwarded first, then input 1 packet after a 1-cycle bubble, with no beat interleaving; pkt_cnt_0=1, pkt_cnt_1=1.
- Fairness: both inputs continuously offer 1-beat packets for 20 packets total -> output strictly alternates source 0,1,0,1,…; each counter reads 10.
- Back-pressure: m_axis_tready held low for 5 cycles mid-packet -> output beat held stable, granted tready=0, no beat lost or duplicated, data identical to the reference model.
- Input stall: granted input drops tvalid for 3 cycles mid-packet while the other input is valid -> grant unchanged, other input's tready stays 0, the packet completes intact.
- Reset mid-packet plus wrap: assert reset during beat 2 of 4 -> outputs become 0 in the same cycle and state returns to IDLE. Separately, with CNT_WIDTH=4, forward 17 packets on input 1 -> pkt_cnt_1=1.
